// File: rtl/instr_fetch_stage_pkg.sv
// Shared types and constants for the MIPS-Lite instruction fetch stage.
package instr_fetch_stage_pkg;

   localparam int unsigned DEF_ADD_WIDTH = 32;
   localparam int unsigned DEF_DATA      = 32;
   localparam int unsigned CNT_W         = 32;
   localparam int unsigned PC_STEP       = 4;

   localparam logic [31:0] DEF_BUBBLE_WORD = 32'hFC00_0000;
   localparam logic [5:0]  OPC_HALT        = 6'h11;

   typedef logic [DEF_DATA-1:0] Instruct;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      HALT_PEND = 2'd1,
      HALTED    = 2'd2
   } fetch_state_e;

   // Event counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold on stall, or replace with a bubble.
module instr_fetch_stage_if_id_reg
   import instr_fetch_stage_pkg::*;
#(
   parameter int unsigned    ADD_WIDTH   = DEF_ADD_WIDTH,
   parameter int unsigned    DATA        = DEF_DATA,
   parameter logic [DATA-1:0] BUBBLE_WORD = DATA'(DEF_BUBBLE_WORD)
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic                 bubble_i,
   input  logic [DATA-1:0]      instr_i,
   input  logic [ADD_WIDTH-1:0] pc_i,
   output logic [DATA-1:0]      instr_o,
   output logic [ADD_WIDTH-1:0] pc_o,
   output logic                 valid_o
);

   logic [DATA-1:0]      instr_q;
   logic [ADD_WIDTH-1:0] pc_q;
   logic                 valid_q;

   // A bubble keeps the old pc so decode still sees a stable address.
   always_ff @(posedge clock) begin
      if (rst) begin
         instr_q <= BUBBLE_WORD;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (bubble_i) begin
         instr_q <= BUBBLE_WORD;
         valid_q <= 1'b0;
      end else if (load_i) begin
         instr_q <= instr_i;
         pc_q    <= pc_i;
         valid_q <= 1'b1;
      end
   end

   assign instr_o = instr_q;
   assign pc_o    = pc_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: owns the PC, fetches from a combinational imem, handles stalls,
// redirects and the HALT shutdown sequence.
module instr_fetch_stage
   import instr_fetch_stage_pkg::*;
#(
   parameter int unsigned          ADD_WIDTH   = DEF_ADD_WIDTH,
   parameter int unsigned          DATA        = DEF_DATA,
   parameter logic [ADD_WIDTH-1:0] RESET_PC    = '0,
   parameter logic [DATA-1:0]      BUBBLE_WORD = DATA'(DEF_BUBBLE_WORD)
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic                 hazard_detected,
   input  logic                 is_taken,
   input  logic [ADD_WIDTH-1:0] branch_target,
   input  logic                 halt_commit,
   output logic [ADD_WIDTH-1:0] imem_addr,
   output logic                 imem_rd_en,
   input  logic [DATA-1:0]      imem_rdata,
   output logic [DATA-1:0]      instr_o,
   output logic [ADD_WIDTH-1:0] pc_o,
   output logic                 valid_o,
   output logic                 fetch_halted,
   output logic [CNT_W-1:0]     fetch_count,
   output logic [CNT_W-1:0]     stall_count,
   output logic [CNT_W-1:0]     flush_count
);

   fetch_state_e         state_q, state_d;
   logic [ADD_WIDTH-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]     fetch_cnt_q, fetch_cnt_d;
   logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
   logic                 ifid_load;
   logic                 ifid_bubble;
   logic                 is_halt_word;

   assign is_halt_word = (imem_rdata[DATA-1 -: 6] == OPC_HALT);

   // Priority: redirect, then stall, then the per-state action. HALTED ignores everything.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      ifid_load   = 1'b0;
      ifid_bubble = (state_q == HALTED);

      if (state_q != HALTED) begin
         if (is_taken) begin
            pc_d        = branch_target & ~ADD_WIDTH'(3);
            ifid_bubble = 1'b1;
            flush_cnt_d = sat_inc(flush_cnt_q);
            state_d     = RUN;
         end else if (hazard_detected) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
            if ((state_q == HALT_PEND) && halt_commit) begin
               state_d = HALTED;
            end
         end else if (state_q == RUN) begin
            ifid_load   = 1'b1;
            fetch_cnt_d = sat_inc(fetch_cnt_q);
            if (is_halt_word) begin
               state_d = HALT_PEND;
            end else begin
               pc_d = pc_q + ADD_WIDTH'(PC_STEP);
            end
         end else begin
            ifid_bubble = 1'b1;
            if (halt_commit) begin
               state_d = HALTED;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q     <= RUN;
         pc_q        <= RESET_PC;
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   instr_fetch_stage_if_id_reg #(
      .ADD_WIDTH   (ADD_WIDTH),
      .DATA        (DATA),
      .BUBBLE_WORD (BUBBLE_WORD)
   ) u_if_id (
      .clock    (clock),
      .rst      (rst),
      .load_i   (ifid_load),
      .bubble_i (ifid_bubble),
      .instr_i  (imem_rdata),
      .pc_i     (pc_q),
      .instr_o  (instr_o),
      .pc_o     (pc_o),
      .valid_o  (valid_o)
   );

   assign imem_addr    = {pc_q[ADD_WIDTH-1:2], 2'b00};
   assign imem_rd_en   = (state_q == RUN) && !hazard_detected && !rst;
   assign fetch_halted = (state_q == HALTED);
   assign fetch_count  = fetch_cnt_q;
   assign stall_count  = stall_cnt_q;
   assign flush_count  = flush_cnt_q;

   // A commit with no HALT in flight means the pipeline control is out of step.
   a_commit_needs_halt: assert property (@(posedge clock) disable iff (rst)
      !(halt_commit && (state_q == RUN)))
      else $error("halt_commit received while fetch stage is in RUN");

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Table-driven bench for instr_fetch_stage with an instruction scoreboard,
// plus hand sequences for PC wrap, counter saturation and stall-during-commit.
module tb_instr_fetch_stage;
   import instr_fetch_stage_pkg::*;

   localparam logic O = 1'b0;
   localparam logic I = 1'b1;
   localparam int   NV = 20;

   logic        clock;
   logic        rst, haz, tk, hc, halt_en;
   logic [31:0] tgt;
   logic [31:0] imem_addr, imem_rdata, instr, pc;
   logic        rd_en, valid, halted;
   logic [31:0] fc, sc, flc;

   logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_fc, w_sc, w_flc;
   logic        w_rd_en, w_valid, w_halted;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic rst, haz, tk; logic [31:0] tgt; logic hc, hlt;
      logic ev; logic [31:0] epc, eaddr; logic erd, ehalt;
      logic [31:0] efc, esc, eflc;
   } vec_t;

   typedef struct packed { logic [31:0] instr; logic [31:0] pc; } sb_t;

   vec_t vecs[NV];
   sb_t  sbq[$];
   sb_t  last;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] word_at(input logic [31:0] a, input logic h);
      if (h && a == 32'h10) return {OPC_HALT, 26'h0};
      return {6'h08, 5'd0, 5'd1, a[15:0]};
   endfunction

   always_comb imem_rdata = word_at(imem_addr, halt_en);
   always_comb w_rdata    = word_at(w_addr, 1'b0);

   instr_fetch_stage dut (
      .clock(clock), .rst(rst), .hazard_detected(haz), .is_taken(tk),
      .branch_target(tgt), .halt_commit(hc), .imem_addr(imem_addr),
      .imem_rd_en(rd_en), .imem_rdata(imem_rdata), .instr_o(instr), .pc_o(pc),
      .valid_o(valid), .fetch_halted(halted), .fetch_count(fc),
      .stall_count(sc), .flush_count(flc)
   );

   instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clock(clock), .rst(rst), .hazard_detected(1'b0), .is_taken(1'b0),
      .branch_target(32'h0), .halt_commit(1'b0), .imem_addr(w_addr),
      .imem_rd_en(w_rd_en), .imem_rdata(w_rdata), .instr_o(w_instr), .pc_o(w_pc),
      .valid_o(w_valid), .fetch_halted(w_halted), .fetch_count(w_fc),
      .stall_count(w_sc), .flush_count(w_flc)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   initial begin
      logic [31:0] prev_addr;
      logic        fetch;

      //        rst haz tk  tgt       hc hlt | ev  pc_o      addr      rd  hlt fc     sc     flc
      vecs[0]  = '{I, O, O, 32'h00, O, O,   O, 32'h00, 32'h00, O, O, 32'd0, 32'd0, 32'd0};
      vecs[1]  = '{O, O, O, 32'h00, O, O,   I, 32'h00, 32'h04, I, O, 32'd1, 32'd0, 32'd0};
      vecs[2]  = '{O, O, O, 32'h00, O, O,   I, 32'h04, 32'h08, I, O, 32'd2, 32'd0, 32'd0};
      vecs[3]  = '{O, I, O, 32'h00, O, O,   I, 32'h04, 32'h08, O, O, 32'd2, 32'd1, 32'd0};
      vecs[4]  = '{O, I, O, 32'h00, O, O,   I, 32'h04, 32'h08, O, O, 32'd2, 32'd2, 32'd0};
      vecs[5]  = '{O, O, O, 32'h00, O, O,   I, 32'h08, 32'h0C, I, O, 32'd3, 32'd2, 32'd0};
      vecs[6]  = '{O, I, I, 32'h43, O, O,   O, 32'h08, 32'h40, O, O, 32'd3, 32'd2, 32'd1};
      vecs[7]  = '{O, O, O, 32'h00, O, O,   I, 32'h40, 32'h44, I, O, 32'd4, 32'd2, 32'd1};
      vecs[8]  = '{O, O, I, 32'h10, O, O,   O, 32'h40, 32'h10, I, O, 32'd4, 32'd2, 32'd2};
      vecs[9]  = '{O, O, O, 32'h00, O, I,   I, 32'h10, 32'h10, O, O, 32'd5, 32'd2, 32'd2};
      vecs[10] = '{O, O, O, 32'h00, O, I,   O, 32'h10, 32'h10, O, O, 32'd5, 32'd2, 32'd2};
      vecs[11] = '{O, O, I, 32'h20, O, I,   O, 32'h10, 32'h20, I, O, 32'd5, 32'd2, 32'd3};
      vecs[12] = '{O, O, O, 32'h00, O, O,   I, 32'h20, 32'h24, I, O, 32'd6, 32'd2, 32'd3};
      vecs[13] = '{O, O, I, 32'h10, O, O,   O, 32'h20, 32'h10, I, O, 32'd6, 32'd2, 32'd4};
      vecs[14] = '{O, O, O, 32'h00, O, I,   I, 32'h10, 32'h10, O, O, 32'd7, 32'd2, 32'd4};
      vecs[15] = '{O, O, O, 32'h00, O, I,   O, 32'h10, 32'h10, O, O, 32'd7, 32'd2, 32'd4};
      vecs[16] = '{O, O, O, 32'h00, I, I,   O, 32'h10, 32'h10, O, I, 32'd7, 32'd2, 32'd4};
      vecs[17] = '{O, I, I, 32'h80, O, I,   O, 32'h10, 32'h10, O, I, 32'd7, 32'd2, 32'd4};
      vecs[18] = '{I, O, O, 32'h00, O, O,   O, 32'h00, 32'h00, O, O, 32'd0, 32'd0, 32'd0};
      vecs[19] = '{O, O, O, 32'h00, O, O,   I, 32'h00, 32'h04, I, O, 32'd1, 32'd0, 32'd0};

      rst = 1'b1; haz = 1'b0; tk = 1'b0; tgt = '0; hc = 1'b0; halt_en = 1'b0;
      last = '0; prev_addr = '0;
      @(negedge clock);

      for (int i = 0; i < NV; i++) begin
         rst = vecs[i].rst; haz = vecs[i].haz; tk = vecs[i].tk;
         tgt = vecs[i].tgt; hc = vecs[i].hc; halt_en = vecs[i].hlt;
         fetch = vecs[i].ev && !vecs[i].haz && !vecs[i].tk && !vecs[i].rst;
         if (fetch) sbq.push_back('{instr: word_at(prev_addr, vecs[i].hlt), pc: prev_addr});
         @(negedge clock);
         if (fetch) begin
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL r%0d scoreboard empty", i);
            end else begin
               last = sbq.pop_front();
            end
         end
         if (valid) begin
            chk($sformatf("r%0d instr", i), instr, last.instr);
            chk($sformatf("r%0d sb_pc", i), pc, last.pc);
         end else begin
            chk($sformatf("r%0d bubble", i), instr, 32'hFC00_0000);
         end
         chk($sformatf("r%0d valid", i), 32'(valid), 32'(vecs[i].ev));
         chk($sformatf("r%0d pc_o", i), pc, vecs[i].epc);
         chk($sformatf("r%0d imem_addr", i), imem_addr, vecs[i].eaddr);
         chk($sformatf("r%0d rd_en", i), 32'(rd_en), 32'(vecs[i].erd));
         chk($sformatf("r%0d halted", i), 32'(halted), 32'(vecs[i].ehalt));
         chk($sformatf("r%0d fetch_cnt", i), fc, vecs[i].efc);
         chk($sformatf("r%0d stall_cnt", i), sc, vecs[i].esc);
         chk($sformatf("r%0d flush_cnt", i), flc, vecs[i].eflc);
         prev_addr = vecs[i].eaddr;
      end

      // PC wrap from the top of the address space, then counter saturation.
      haz = 1'b0; tk = 1'b0; hc = 1'b0; halt_en = 1'b0;
      rst = 1'b1;
      @(negedge clock);
      rst = 1'b0;
      chk("wrap reset addr", w_addr, 32'hFFFF_FFFC);
      chk("wrap reset valid", 32'(w_valid), 32'd0);
      @(negedge clock);
      chk("wrap pc_o", w_pc, 32'hFFFF_FFFC);
      chk("wrap valid", 32'(w_valid), 32'd1);
      chk("wrap next addr", w_addr, 32'h0);
      @(negedge clock);
      chk("wrap pc0", w_pc, 32'h0);
      chk("wrap instr0", w_instr, word_at(32'h0, 1'b0));
      chk("wrap addr4", w_addr, 32'h4);
      chk("wrap fetch_cnt", w_fc, 32'd2);
      chk("wrap rd_en", 32'(w_rd_en), 32'd1);
      chk("wrap halted", 32'(w_halted), 32'd0);
      chk("wrap stall/flush", w_sc | w_flc, 32'd0);
      force dut_w.fetch_cnt_q = 32'hFFFF_FFFE;
      #1 release dut_w.fetch_cnt_q;
      @(negedge clock);
      chk("sat reach max", w_fc, 32'hFFFF_FFFF);
      @(negedge clock);
      chk("sat hold max", w_fc, 32'hFFFF_FFFF);

      // Commit arriving during a stall still retires fetch; held HALT then drops to a bubble.
      tk = 1'b1; tgt = 32'h10;
      @(negedge clock);
      tk = 1'b0; halt_en = 1'b1;
      @(negedge clock);
      chk("hp fetch halt", instr, {OPC_HALT, 26'h0});
      haz = 1'b1; hc = 1'b1;
      @(negedge clock);
      haz = 1'b0; hc = 1'b0;
      chk("hp halted", 32'(halted), 32'd1);
      chk("hp held valid", 32'(valid), 32'd1);
      @(negedge clock);
      chk("hp bubble valid", 32'(valid), 32'd0);
      chk("hp pc frozen", pc, 32'h10);
      chk("hp addr frozen", imem_addr, 32'h10);
      chk("hp rd_en", 32'(rd_en), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
